// File: rtl/raisin64_pkg.sv
// Shared types and constants for the raisin64 writeback path.
// Unit indices fix the round-robin scan order of the writeback arbiter.
package raisin64_pkg;

  localparam int NUNITS      = 5;
  localparam int REG_W       = 6;
  localparam int DATA_W      = 64;

  localparam int UNIT_ALU1    = 0;
  localparam int UNIT_ALU2    = 1;
  localparam int UNIT_ADVINT  = 2;
  localparam int UNIT_MEMUNIT = 3;
  localparam int UNIT_BRANCH  = 4;

  typedef logic [REG_W-1:0]  reg_num_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [2:0]        unit_idx_t;

  // A result normalised to the writes it needs: demand is 0, 1 or 2 ports.
  typedef struct packed {
    logic [1:0] demand;
    reg_num_t   rd1;
    data_t      data1;
    reg_num_t   rd2;
    data_t      data2;
  } result_t;

  function automatic unit_idx_t next_unit(unit_idx_t u);
    return (u == unit_idx_t'(NUNITS - 1)) ? '0 : u + 1'b1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Execution-unit result handshakes plus the two register-file write ports.
// The arbiter takes the slave view; the unit/regfile environment takes master.
interface wb_arbiter_if;
  import raisin64_pkg::*;

  logic     alu1_done,    alu2_done,    advint_done,    memunit_done,    branch_done;
  reg_num_t alu1_rd,      alu2_rd,      advint_rd,      memunit_rd,      branch_rd;
  data_t    alu1_data,    alu2_data,    advint_data,    memunit_data,    branch_data;
  reg_num_t advint_rd2;
  data_t    advint_data2;
  logic     alu1_ack,     alu2_ack,     advint_ack,     memunit_ack,     branch_ack;

  logic     wr1_en,  wr2_en;
  reg_num_t wr1_rn,  wr2_rn;
  data_t    wr1_data, wr2_data;
  reg_num_t reg1_finished, reg2_finished;

  modport slave (
    input  alu1_done, alu2_done, advint_done, memunit_done, branch_done,
    input  alu1_rd, alu2_rd, advint_rd, memunit_rd, branch_rd,
    input  alu1_data, alu2_data, advint_data, memunit_data, branch_data,
    input  advint_rd2, advint_data2,
    output alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack,
    output wr1_en, wr2_en, wr1_rn, wr2_rn, wr1_data, wr2_data,
    output reg1_finished, reg2_finished
  );

  modport master (
    output alu1_done, alu2_done, advint_done, memunit_done, branch_done,
    output alu1_rd, alu2_rd, advint_rd, memunit_rd, branch_rd,
    output alu1_data, alu2_data, advint_data, memunit_data, branch_data,
    output advint_rd2, advint_data2,
    input  alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack,
    input  wr1_en, wr2_en, wr1_rn, wr2_rn, wr1_data, wr2_data,
    input  reg1_finished, reg2_finished
  );

endinterface

// File: rtl/rr_pick.sv
// Circular find-first-set over the requesters, starting at index `start`.
module rr_pick
  import raisin64_pkg::*;
(
  input  logic [NUNITS-1:0] req,
  input  unit_idx_t         start,
  output logic              hit,
  output unit_idx_t         idx
);

  unit_idx_t cand;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = start;
    for (int i = 0; i < NUNITS; i++) begin
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
      cand = next_unit(cand);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to two register-file writes per cycle among the
// five execution units with round-robin fairness; acks are combinational.
module wb_arbiter
  import raisin64_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);

  logic [NUNITS-1:0] done_vec;
  reg_num_t          unit_rd   [NUNITS];
  data_t             unit_data [NUNITS];
  result_t           res       [NUNITS];
  logic [NUNITS-1:0] req_vec, zero_vec, one_vec;

  assign done_vec = {bus.branch_done, bus.memunit_done, bus.advint_done,
                     bus.alu2_done, bus.alu1_done};

  assign unit_rd[UNIT_ALU1]      = bus.alu1_rd;
  assign unit_rd[UNIT_ALU2]      = bus.alu2_rd;
  assign unit_rd[UNIT_ADVINT]    = bus.advint_rd;
  assign unit_rd[UNIT_MEMUNIT]   = bus.memunit_rd;
  assign unit_rd[UNIT_BRANCH]    = bus.branch_rd;
  assign unit_data[UNIT_ALU1]    = bus.alu1_data;
  assign unit_data[UNIT_ALU2]    = bus.alu2_data;
  assign unit_data[UNIT_ADVINT]  = bus.advint_data;
  assign unit_data[UNIT_MEMUNIT] = bus.memunit_data;
  assign unit_data[UNIT_BRANCH]  = bus.branch_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUNITS; gi++) begin : g_res
      if (gi == UNIT_ADVINT) begin : g_adv
        result_t r;
        // Identical rd/rd2 collapses to one write; the second value wins.
        always_comb begin
          r = '0;
          if (bus.advint_rd != '0 && bus.advint_rd2 != '0) begin
            if (bus.advint_rd == bus.advint_rd2) begin
              r.demand = 2'd1;
              r.rd1    = bus.advint_rd;
              r.data1  = bus.advint_data2;
            end else begin
              r.demand = 2'd2;
              r.rd1    = bus.advint_rd;
              r.data1  = bus.advint_data;
              r.rd2    = bus.advint_rd2;
              r.data2  = bus.advint_data2;
            end
          end else if (bus.advint_rd != '0) begin
            r.demand = 2'd1;
            r.rd1    = bus.advint_rd;
            r.data1  = bus.advint_data;
          end else if (bus.advint_rd2 != '0) begin
            r.demand = 2'd1;
            r.rd1    = bus.advint_rd2;
            r.data1  = bus.advint_data2;
          end
        end
        assign res[gi] = r;
      end else begin : g_single
        assign res[gi] = '{demand: (unit_rd[gi] != '0) ? 2'd1 : 2'd0,
                           rd1: unit_rd[gi], data1: unit_data[gi],
                           rd2: '0, data2: '0};
      end
      assign req_vec[gi]  = done_vec[gi] && (res[gi].demand != 2'd0);
      assign zero_vec[gi] = done_vec[gi] && (res[gi].demand == 2'd0);
      assign one_vec[gi]  = (res[gi].demand == 2'd1);
    end
  endgenerate

  unit_idx_t         ptr_reg;
  logic              a_hit, b_hit, a_single, a_double, b_grant;
  unit_idx_t         a_idx, b_idx, b_start;
  logic [NUNITS-1:0] a_onehot, b_onehot, b_req, ack_vec;
  result_t           a_res;

  rr_pick u_pick_a (.req(req_vec), .start(ptr_reg), .hit(a_hit), .idx(a_idx));

  always_comb begin
    a_onehot        = '0;
    a_onehot[a_idx] = a_hit;
  end

  assign b_start = next_unit(a_idx);
  assign b_req   = req_vec & one_vec & ~a_onehot;

  rr_pick u_pick_b (.req(b_req), .start(b_start), .hit(b_hit), .idx(b_idx));

  assign a_res    = res[a_idx];
  assign a_single = a_hit && (a_res.demand == 2'd1);
  assign a_double = a_hit && (a_res.demand == 2'd2);
  // A same-register B would race A's write, so it waits a cycle.
  assign b_grant  = a_single && b_hit && (res[b_idx].rd1 != a_res.rd1);

  always_comb begin
    b_onehot        = '0;
    b_onehot[b_idx] = b_grant;
  end

  assign ack_vec = rst_n ? (zero_vec | a_onehot | b_onehot) : '0;

  assign bus.alu1_ack    = ack_vec[UNIT_ALU1];
  assign bus.alu2_ack    = ack_vec[UNIT_ALU2];
  assign bus.advint_ack  = ack_vec[UNIT_ADVINT];
  assign bus.memunit_ack = ack_vec[UNIT_MEMUNIT];
  assign bus.branch_ack  = ack_vec[UNIT_BRANCH];

  logic     wr1_en_reg, wr2_en_reg;
  reg_num_t wr1_rn_reg, wr2_rn_reg, reg1_fin_reg, reg2_fin_reg;
  data_t    wr1_data_reg, wr2_data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      wr1_en_reg   <= 1'b0;
      wr2_en_reg   <= 1'b0;
      wr1_rn_reg   <= '0;
      wr2_rn_reg   <= '0;
      wr1_data_reg <= '0;
      wr2_data_reg <= '0;
      reg1_fin_reg <= '0;
      reg2_fin_reg <= '0;
    end else begin
      wr1_en_reg   <= a_hit;
      reg1_fin_reg <= a_hit ? a_res.rd1 : '0;
      if (a_hit) begin
        wr1_rn_reg   <= a_res.rd1;
        wr1_data_reg <= a_res.data1;
        ptr_reg      <= next_unit(a_idx);
      end
      wr2_en_reg   <= a_double || b_grant;
      reg2_fin_reg <= a_double ? a_res.rd2 : (b_grant ? res[b_idx].rd1 : '0);
      if (a_double) begin
        wr2_rn_reg   <= a_res.rd2;
        wr2_data_reg <= a_res.data2;
      end else if (b_grant) begin
        wr2_rn_reg   <= res[b_idx].rd1;
        wr2_data_reg <= res[b_idx].data1;
      end
    end
  end

  assign bus.wr1_en        = wr1_en_reg;
  assign bus.wr2_en        = wr2_en_reg;
  assign bus.wr1_rn        = wr1_rn_reg;
  assign bus.wr2_rn        = wr2_rn_reg;
  assign bus.wr1_data      = wr1_data_reg;
  assign bus.wr2_data      = wr2_data_reg;
  assign bus.reg1_finished = reg1_fin_reg;
  assign bus.reg2_finished = reg2_fin_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random checks of wb_arbiter against a queue-based model of the
// grant rules (rotation order list, per-cycle write list).
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus();
  wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Unit-side pending results
  logic        t_done [5];
  logic [5:0]  t_rd   [5];
  logic [63:0] t_data [5];
  logic [5:0]  t_rd2;
  logic [63:0] t_data2;

  // Model state
  int          m_ptr = 0;
  logic        e_ack [5];
  logic        e_en1 = 0, e_en2 = 0, n_en1, n_en2;
  logic [5:0]  e_rn1 = 0, e_rn2 = 0, n_rn1, n_rn2;
  logic [63:0] e_d1 = 0, e_d2 = 0, n_d1, n_d2;
  int          wait_cnt [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    bus.alu1_done = t_done[0];    bus.alu1_rd = t_rd[0];    bus.alu1_data = t_data[0];
    bus.alu2_done = t_done[1];    bus.alu2_rd = t_rd[1];    bus.alu2_data = t_data[1];
    bus.advint_done = t_done[2];  bus.advint_rd = t_rd[2];  bus.advint_data = t_data[2];
    bus.memunit_done = t_done[3]; bus.memunit_rd = t_rd[3]; bus.memunit_data = t_data[3];
    bus.branch_done = t_done[4];  bus.branch_rd = t_rd[4];  bus.branch_data = t_data[4];
    bus.advint_rd2 = t_rd2;       bus.advint_data2 = t_data2;
  endtask

  function automatic int dem(int u);
    if (u == 2) begin
      if (t_rd[2] != 0 && t_rd2 != 0) return (t_rd[2] == t_rd2) ? 1 : 2;
      return (t_rd[2] != 0 || t_rd2 != 0) ? 1 : 0;
    end
    return (t_rd[u] != 0) ? 1 : 0;
  endfunction

  function automatic logic [5:0] first_rd(int u);
    if (u == 2 && t_rd[2] == 0) return t_rd2;
    return t_rd[u];
  endfunction

  function automatic logic [63:0] first_data(int u);
    if (u == 2 && (t_rd[2] == 0 || t_rd[2] == t_rd2)) return t_data2;
    return t_data[u];
  endfunction

  // Builds the ordered list of writes granted this cycle and the ack set.
  task automatic model_step();
    logic [5:0]  q_rn [$];
    logic [63:0] q_d  [$];
    int a = -1, b = -1;
    for (int u = 0; u < 5; u++) e_ack[u] = 1'b0;
    n_en1 = 0; n_en2 = 0;
    n_rn1 = e_rn1; n_rn2 = e_rn2; n_d1 = e_d1; n_d2 = e_d2;
    if (!rst_n) begin
      m_ptr = 0;
      n_rn1 = 0; n_rn2 = 0; n_d1 = 0; n_d2 = 0;
      return;
    end
    for (int u = 0; u < 5; u++)
      if (t_done[u] && dem(u) == 0) e_ack[u] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int u = (m_ptr + k) % 5;
      if (a < 0 && t_done[u] && dem(u) > 0) a = u;
    end
    if (a >= 0) begin
      e_ack[a] = 1'b1;
      q_rn.push_back(first_rd(a));
      q_d.push_back(first_data(a));
      if (dem(a) == 2) begin
        q_rn.push_back(t_rd2);
        q_d.push_back(t_data2);
      end else begin
        for (int k = 1; k < 5; k++) begin
          int u = (a + k) % 5;
          if (b < 0 && t_done[u] && dem(u) == 1) b = u;
        end
        if (b >= 0 && first_rd(b) != first_rd(a)) begin
          e_ack[b] = 1'b1;
          q_rn.push_back(first_rd(b));
          q_d.push_back(first_data(b));
        end
      end
      m_ptr = (a + 1) % 5;
    end
    if (q_rn.size() >= 1) begin n_en1 = 1; n_rn1 = q_rn[0]; n_d1 = q_d[0]; end
    if (q_rn.size() >= 2) begin n_en2 = 1; n_rn2 = q_rn[1]; n_d2 = q_d[1]; end
  endtask

  // One clock: check registered outputs, then acks, then retire acked results.
  task automatic tick();
    logic obs_ack [5];
    drive_bus();
    @(negedge clk);
    chk("wr1_en", 64'(bus.wr1_en), 64'(e_en1));
    chk("wr1_rn", 64'(bus.wr1_rn), 64'(e_rn1));
    chk("wr1_data", bus.wr1_data, e_d1);
    chk("reg1_finished", 64'(bus.reg1_finished), 64'(e_en1 ? e_rn1 : 6'd0));
    chk("wr2_en", 64'(bus.wr2_en), 64'(e_en2));
    chk("wr2_rn", 64'(bus.wr2_rn), 64'(e_rn2));
    chk("wr2_data", bus.wr2_data, e_d2);
    chk("reg2_finished", 64'(bus.reg2_finished), 64'(e_en2 ? e_rn2 : 6'd0));
    model_step();
    obs_ack[0] = bus.alu1_ack;   obs_ack[1] = bus.alu2_ack;
    obs_ack[2] = bus.advint_ack; obs_ack[3] = bus.memunit_ack;
    obs_ack[4] = bus.branch_ack;
    for (int u = 0; u < 5; u++) begin
      chk($sformatf("ack_u%0d", u), 64'(obs_ack[u]), 64'(e_ack[u]));
      if (rst_n && t_done[u] && dem(u) > 0 && !e_ack[u]) wait_cnt[u]++;
      else wait_cnt[u] = 0;
      chk($sformatf("fair_u%0d", u), 64'(wait_cnt[u] <= 4), 64'd1);
    end
    @(posedge clk);
    e_en1 = n_en1; e_en2 = n_en2; e_rn1 = n_rn1; e_rn2 = n_rn2; e_d1 = n_d1; e_d2 = n_d2;
    #1;
    for (int u = 0; u < 5; u++) if (e_ack[u]) t_done[u] = 1'b0;
    drive_bus();
  endtask

  task automatic clear_units();
    for (int u = 0; u < 5; u++) begin
      t_done[u] = 0; t_rd[u] = 0; t_data[u] = 0; wait_cnt[u] = 0;
    end
    t_rd2 = 0; t_data2 = 0;
  endtask

  task automatic present(input int u, input logic [5:0] rd, input logic [63:0] data);
    t_done[u] = 1'b1; t_rd[u] = rd; t_data[u] = data;
  endtask

  initial begin
    clear_units();
    for (int u = 0; u < 5; u++) present(u, 6'(u + 1), 64'(32'h1000 + u));
    t_rd2 = 6'd6; t_data2 = 64'h2000;
    drive_bus();
    @(posedge clk);
    #1;
    // Reset held with everything pending: no acks, zero outputs
    repeat (3) tick();
    rst_n = 1'b1;

    // All five held done back-to-back: rotation and fairness
    repeat (12) begin
      tick();
      for (int u = 0; u < 5; u++)
        if (!t_done[u]) present(u, 6'(u + 1), 64'($urandom));
    end
    clear_units();
    repeat (2) tick();

    // Single ALU1 write
    present(0, 6'd5, 64'hDEAD);
    repeat (2) tick();

    // Branch alone leaves ptr=0, then same-rd collision on ALU1/ALU2
    present(4, 6'd12, 64'h12);
    tick();
    present(0, 6'd7, 64'h7A);
    present(1, 6'd7, 64'h7B);
    repeat (3) tick();

    // Store (rd=0) acked alongside two ALU writes
    present(3, 6'd0, 64'h5);
    present(0, 6'd3, 64'h33);
    present(1, 6'd4, 64'h44);
    repeat (2) tick();

    // AdvInt alone sets ptr=3; then AdvInt dual vs MemUnit
    present(2, 6'd11, 64'hB1);
    t_rd2 = 6'd0;
    tick();
    present(2, 6'd8, 64'h88);
    t_rd2 = 6'd9; t_data2 = 64'h99;
    present(3, 6'd10, 64'hAA);
    repeat (3) tick();

    // AdvInt rd==rd2 collapses to one write of data2
    present(2, 6'd13, 64'hC1);
    t_rd2 = 6'd13; t_data2 = 64'hC2;
    repeat (2) tick();

    // Random traffic with small register space for collisions and stores
    repeat (400) begin
      for (int u = 0; u < 5; u++) begin
        if (!t_done[u] && $urandom_range(0, 9) < 7) begin
          present(u, 6'($urandom_range(0, 7)), {$urandom, $urandom});
          if (u == 2) begin
            t_rd2 = 6'($urandom_range(0, 7));
            t_data2 = {$urandom, $urandom};
          end
        end
      end
      tick();
    end
    clear_units();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
